dut_scheduler: RTL and testbench

DUT_SCHEDULER -- requirements
Module: dut_scheduler

---
 rtl/dut_sched_pkg.sv | 17 +
 rtl/dut_sched_if.sv | 36 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/dut_scheduler.sv | 140 ++++++++++++++
 tb/tb_dut_scheduler.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dut_sched_pkg.sv
// rtl/dut_sched_pkg.sv - shared state encoding and default constants for the serial scheduler
package dut_sched_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int WIDTH_DEF   = 8;
    localparam int DUT_LATENCY = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_FLUSH = 3'd4,
        S_RESP  = 3'd5
    } sched_state_e;

endpackage

// File: rtl/dut_sched_if.sv
// rtl/dut_sched_if.sv - request, serial datapath and response signals of the scheduler
interface dut_sched_if
    import dut_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
);

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  dut_d_in;
    logic                  dut_rst;
    logic                  dut_d_out;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;
    logic                  busy;

    // Scheduler side.
    modport slave (
        input  req_valid, req_data, dut_d_out, rsp_ready,
        output req_ready, dut_d_in, dut_rst, rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    // Requester / datapath / consumer side.
    modport master (
        output req_valid, req_data, dut_d_out, rsp_ready,
        input  req_ready, dut_d_in, dut_rst, rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at the pointer position
module rr_arbiter
    import dut_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [IDW-1:0] w_k;

    // Walk from ptr upwards with wrap; the first requester found wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_k     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_k = IDW'((int'(i_ptr) + i) % NREQ);
            if (!o_any && i_req[w_k]) begin
                o_any        = 1'b1;
                o_idx        = w_k;
                o_grant[w_k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dut_scheduler.sv
// rtl/dut_scheduler.sv - arbitrates requesters onto a 1-bit pipelined datapath and returns the echoed word
module dut_scheduler
    import dut_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic  clk,
    input  logic  rst,
    dut_sched_if.slave sif
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH + DUT_LATENCY) + 1;

    localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(WIDTH - 1 + DUT_LATENCY);
    localparam logic [CW-1:0] CAP_FIRST  = CW'(DUT_LATENCY);

    sched_state_e     r_state;
    sched_state_e     w_next;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_cap;
    logic [CW-1:0]    r_cnt;
    logic             r_d_in;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_err;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic [WIDTH-1:0] w_word;
    logic [NREQ-1:0]  w_req_ready;
    logic             w_busy;
    logic             w_rsp_valid;
    logic             w_flush;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req   (sif.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_word = sif.req_data[w_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // r_cnt runs continuously across SHIFT and DRAIN so capture can key off one counter.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (|sif.req_valid) w_next = S_ARB;
            S_ARB:   w_next = w_any ? S_SHIFT : S_IDLE;
            S_SHIFT: if (r_cnt == SHIFT_LAST) w_next = S_DRAIN;
            S_DRAIN: if (r_cnt == DRAIN_LAST) w_next = S_FLUSH;
            S_FLUSH: w_next = S_RESP;
            S_RESP:  if (sif.rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready = '0;
        w_busy      = (r_state != S_IDLE);
        w_rsp_valid = (r_state == S_RESP);
        w_flush     = (r_state == S_FLUSH);
        if (r_state == S_ARB) begin
            w_req_ready = w_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_id       <= '0;
            r_word     <= '0;
            r_sreg     <= '0;
            r_cap      <= '0;
            r_cnt      <= '0;
            r_d_in     <= 1'b0;
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_d_in <= 1'b0;
            case (r_state)
                S_ARB: begin
                    if (w_any) begin
                        r_ptr  <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
                        r_id   <= w_idx;
                        r_word <= w_word;
                        r_sreg <= w_word << 1;
                        r_d_in <= w_word[WIDTH-1];
                        r_cnt  <= '0;
                        r_cap  <= '0;
                    end
                end
                S_SHIFT, S_DRAIN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt >= CAP_FIRST) begin
                        r_cap <= (r_cap << 1) | WIDTH'(sif.dut_d_out);
                    end
                    if (r_state == S_SHIFT && r_cnt != SHIFT_LAST) begin
                        r_d_in <= r_sreg[WIDTH-1];
                        r_sreg <= r_sreg << 1;
                    end
                end
                S_FLUSH: begin
                    r_rsp_id   <= r_id;
                    r_rsp_data <= r_cap;
                    r_rsp_err  <= (r_cap != r_word);
                end
                default: begin
                end
            endcase
        end
    end

    assign sif.req_ready = w_req_ready;
    assign sif.dut_d_in  = r_d_in;
    assign sif.dut_rst   = rst | w_flush;
    assign sif.rsp_valid = w_rsp_valid;
    assign sif.rsp_id    = r_rsp_id;
    assign sif.rsp_data  = r_rsp_data;
    assign sif.rsp_err   = r_rsp_err;
    assign sif.busy      = w_busy;

endmodule

// File: tb/tb_dut_scheduler.sv
// tb/tb_dut_scheduler.sv - directed self-checking bench for dut_scheduler with a 2-cycle serial datapath model
module tb_dut_scheduler;

    logic clk;
    logic rst;
    int   vec  = 0;
    int   errs = 0;
    bit   auto_drop = 1'b1;
    bit   stuck = 1'b0;

    dut_sched_if #(.NREQ(4), .WIDTH(8)) bus ();

    dut_scheduler #(.NREQ(4), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .sif (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath: two-stage pipeline; sc counts SHIFT cycles so a word bit can be forced low.
    logic p1_bit = 1'b0, p2_bit = 1'b0;
    int   p1_pos = -1, p2_pos = -1, sc = 0;
    always @(posedge clk) begin
        if (bus.req_ready != 4'b0) sc <= 0;
        else sc <= sc + 1;
        if (bus.dut_rst) begin
            p1_bit <= 1'b0; p2_bit <= 1'b0; p1_pos <= -1; p2_pos <= -1;
        end else begin
            p1_bit <= bus.dut_d_in; p1_pos <= sc;
            p2_bit <= p1_bit;       p2_pos <= p1_pos;
        end
    end
    assign bus.dut_d_out = p2_bit & ~(stuck && p2_pos == 4);

    task automatic step();
        logic [3:0] acc;
        acc = bus.req_ready;
        @(negedge clk);
        if (auto_drop) bus.req_valid = bus.req_valid & ~acc;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        vec++; if (bus.req_ready !== 4'b0) begin errs++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready); end
        vec++; if (bus.dut_d_in !== 1'b0) begin errs++; $display("FAIL reset_dut_d_in got %b exp 0", bus.dut_d_in); end
        vec++; if (bus.dut_rst !== 1'b1) begin errs++; $display("FAIL reset_dut_rst got %b exp 1", bus.dut_rst); end
        vec++; if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
        vec++; if (bus.rsp_id !== 2'd0) begin errs++; $display("FAIL reset_rsp_id got %0d exp 0", bus.rsp_id); end
        vec++; if (bus.rsp_data !== 8'h00) begin errs++; $display("FAIL reset_rsp_data got %h exp 00", bus.rsp_data); end
        vec++; if (bus.rsp_err !== 1'b0) begin errs++; $display("FAIL reset_rsp_err got %b exp 0", bus.rsp_err); end
        vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        rst = 1'b0;
        #1;
        vec++; if (bus.dut_rst !== 1'b0) begin errs++; $display("FAIL reset_release_dut_rst got %b exp 0", bus.dut_rst); end
    endtask

    // Cycle 0 is the IDLE cycle in which req_valid is raised; ARB follows in cycle 1.
    task automatic test_single();
        int lat = -1, pulses = 0;
        logic [7:0] sh = '0, d = '0;
        logic [3:0] g = '0;
        logic [1:0] id = '0;
        logic e = 1'b0, fl = 1'b0, dr = 1'b1, v14 = 1'b1, b5 = 1'b0;
        bus.req_data = '0;
        bus.req_data[15:8] = 8'hA5;
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b1;
        #1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.req_ready != 4'b0) begin pulses++; g = bus.req_ready; end
            if (c >= 2 && c <= 9) sh = {sh[6:0], bus.dut_d_in};
            if (c == 5) b5 = bus.busy;
            if (c == 11) dr = bus.dut_rst;
            if (c == 12) fl = bus.dut_rst;
            if (c == 14) v14 = bus.rsp_valid;
            if (bus.rsp_valid && lat < 0) begin lat = c; id = bus.rsp_id; d = bus.rsp_data; e = bus.rsp_err; end
        end
        vec++; if (pulses !== 1) begin errs++; $display("FAIL single_pulses got %0d exp 1", pulses); end
        vec++; if (g !== 4'b0010) begin errs++; $display("FAIL single_grant got %b exp 0010", g); end
        vec++; if (sh !== 8'hA5) begin errs++; $display("FAIL single_serial got %h exp a5", sh); end
        vec++; if (b5 !== 1'b1) begin errs++; $display("FAIL single_busy got %b exp 1", b5); end
        vec++; if (dr !== 1'b0) begin errs++; $display("FAIL single_drain_dut_rst got %b exp 0", dr); end
        vec++; if (fl !== 1'b1) begin errs++; $display("FAIL single_flush_dut_rst got %b exp 1", fl); end
        vec++; if (lat !== 13) begin errs++; $display("FAIL single_latency got %0d exp 13", lat); end
        vec++; if (id !== 2'd1) begin errs++; $display("FAIL single_rsp_id got %0d exp 1", id); end
        vec++; if (d !== 8'hA5) begin errs++; $display("FAIL single_rsp_data got %h exp a5", d); end
        vec++; if (e !== 1'b0) begin errs++; $display("FAIL single_rsp_err got %b exp 0", e); end
        vec++; if (v14 !== 1'b0) begin errs++; $display("FAIL single_rsp_after_hs got %b exp 0", v14); end
    endtask

    task automatic test_round_robin();
        int gr[5], rid[5], rcyc[5];
        logic [7:0] rdat[5];
        logic [7:0] exp_d[4];
        logic err0 = 1'b1;
        int ng = 0, nr = 0, gi;
        exp_d[0] = 8'h3C; exp_d[1] = 8'hC3; exp_d[2] = 8'h5A; exp_d[3] = 8'h96;
        for (int i = 0; i < 5; i++) begin gr[i] = -1; rid[i] = -1; rcyc[i] = -1; rdat[i] = 8'h00; end
        do_reset();
        auto_drop = 1'b0;
        bus.req_data = {8'h96, 8'h5A, 8'hC3, 8'h3C};
        bus.req_valid = 4'b1111;
        for (int c = 1; c <= 75; c++) begin
            step();
            if (bus.req_ready != 4'b0 && ng < 5) begin
                gi = -1;
                for (int b = 0; b < 4; b++) if (bus.req_ready[b]) gi = b;
                gr[ng] = gi; ng++;
            end
            if (bus.rsp_valid && nr < 5) begin
                if (nr == 0) err0 = bus.rsp_err;
                rid[nr] = int'(bus.rsp_id); rdat[nr] = bus.rsp_data; rcyc[nr] = c; nr++;
            end
        end
        auto_drop = 1'b1;
        bus.req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            vec++; if (gr[i] !== i % 4) begin errs++; $display("FAIL rr_grant%0d got %0d exp %0d", i, gr[i], i % 4); end
            vec++; if (rid[i] !== i % 4) begin errs++; $display("FAIL rr_rsp_id%0d got %0d exp %0d", i, rid[i], i % 4); end
            vec++; if (rdat[i] !== exp_d[i % 4]) begin errs++; $display("FAIL rr_rsp_data%0d got %h exp %h", i, rdat[i], exp_d[i % 4]); end
        end
        vec++; if (err0 !== 1'b0) begin errs++; $display("FAIL rr_rsp_err got %b exp 0", err0); end
        vec++; if (rcyc[1] - rcyc[0] !== 14) begin errs++; $display("FAIL rr_period got %0d exp 14", rcyc[1] - rcyc[0]); end
    endtask

    task automatic test_stuck_bit();
        logic [7:0] d = '0;
        logic e = 1'b0;
        logic [1:0] id = '0;
        bit seen = 1'b0;
        do_reset();
        stuck = 1'b1;
        bus.req_data = '0;
        bus.req_data[23:16] = 8'hFF;
        bus.req_valid = 4'b0100;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.rsp_valid && !seen) begin seen = 1'b1; d = bus.rsp_data; e = bus.rsp_err; id = bus.rsp_id; end
        end
        stuck = 1'b0;
        vec++; if (d !== 8'hF7) begin errs++; $display("FAIL stuck_rsp_data got %h exp f7", d); end
        vec++; if (e !== 1'b1) begin errs++; $display("FAIL stuck_rsp_err got %b exp 1", e); end
        vec++; if (id !== 2'd2) begin errs++; $display("FAIL stuck_rsp_id got %0d exp 2", id); end
    endtask

    // Leaves the scheduler in the ARB cycle for requester 0, which the next test aborts.
    task automatic test_backpressure();
        bit seen = 1'b0;
        do_reset();
        bus.rsp_ready = 1'b0;
        bus.req_data = '0;
        bus.req_data[31:24] = 8'h69;
        bus.req_valid = 4'b1000;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 3) begin bus.req_data[7:0] = 8'h0F; bus.req_valid = bus.req_valid | 4'b0001; end
            if (bus.rsp_valid) begin seen = 1'b1; break; end
        end
        vec++; if (seen !== 1'b1) begin errs++; $display("FAIL bp_rsp_seen got %b exp 1", seen); end
        for (int r = 0; r < 5; r++) begin
            if (r > 0) step();
            vec++;
            if ({bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_id, bus.rsp_data, bus.rsp_err} !==
                {1'b1, 1'b1, 4'b0000, 2'd3, 8'h69, 1'b0}) begin
                errs++;
                $display("FAIL bp_hold%0d got v=%b busy=%b rdy=%b id=%0d d=%h e=%b exp v=1 busy=1 rdy=0000 id=3 d=69 e=0",
                         r, bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_id, bus.rsp_data, bus.rsp_err);
            end
        end
        step();
        bus.rsp_ready = 1'b1;
        #1;
        vec++; if (bus.rsp_valid !== 1'b1) begin errs++; $display("FAIL bp_hs_valid got %b exp 1", bus.rsp_valid); end
        step();
        vec++; if ({bus.busy, bus.rsp_valid} !== 2'b00) begin errs++; $display("FAIL bp_idle got busy=%b v=%b exp 0 0", bus.busy, bus.rsp_valid); end
        step();
        vec++; if (bus.req_ready !== 4'b0001) begin errs++; $display("FAIL bp_next_grant got %b exp 0001", bus.req_ready); end
    endtask

    task automatic test_reset_mid_shift();
        bit leak = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        #1;
        vec++; if (bus.dut_rst !== 1'b1) begin errs++; $display("FAIL abort_dut_rst got %b exp 1", bus.dut_rst); end
        step();
        vec++;
        if ({bus.busy, bus.rsp_valid, bus.req_ready, bus.dut_d_in, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== 17'd0) begin
            errs++;
            $display("FAIL abort_outputs got busy=%b v=%b rdy=%b din=%b id=%0d d=%h e=%b exp all 0",
                     bus.busy, bus.rsp_valid, bus.req_ready, bus.dut_d_in, bus.rsp_id, bus.rsp_data, bus.rsp_err);
        end
        rst = 1'b0;
        #1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.busy || bus.rsp_valid) leak = 1'b1;
        end
        vec++; if (leak !== 1'b0) begin errs++; $display("FAIL abort_no_response got %b exp 0", leak); end
    endtask

    task automatic test_arb_drop();
        do_reset();
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = 4'b0000;
        #1;
        vec++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL drop_req_ready got %b exp 0000", bus.req_ready); end
        step();
        vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL drop_idle_busy got %b exp 0", bus.busy); end
        bus.req_valid = 4'b1111;
        step();
        vec++; if (bus.req_ready !== 4'b0001) begin errs++; $display("FAIL drop_ptr_kept got %b exp 0001", bus.req_ready); end
        bus.req_valid = 4'b0000;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_stuck_bit();
        test_backpressure();
        test_reset_mid_shift();
        test_arb_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
